// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: source/destination tags in, forwarding selects and stall/flush out.
// Perf counter outputs stall_cnt/flush_cnt are present only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
  parameter int NSRC = 2
);
  logic [NSRC*5-1:0] src_d;
  logic [NSRC*5-1:0] src_e;
  logic              regwrite_e;
  logic              memread_e;
  logic [4:0]        rd_e;
  logic              regwrite_m;
  logic [4:0]        rd_m;
  logic              regwrite_w;
  logic [4:0]        rd_w;
  logic              branch_taken_e;
  logic [NSRC*3-1:0] fwd_sel;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  modport master (
    output src_d, src_e, regwrite_e, memread_e, rd_e, regwrite_m, rd_m,
    output regwrite_w, rd_w, branch_taken_e,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  fwd_sel, stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  src_d, src_e, regwrite_e, memread_e, rd_e, regwrite_m, rd_m,
    input  regwrite_w, rd_w, branch_taken_e,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output fwd_sel, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: operand forwarding (M > W > history), load-use stall FSM, branch flush.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl_unit #(
  parameter int NSRC     = 2,
  parameter int HIST     = 1,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz
);
  localparam int HD = (HIST > 0) ? HIST : 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [HD-1:0]     hist_we_q;
  logic [4:0]        hist_rd_q [HD];
  logic [NSRC*3-1:0] fwd_sel_s;
  logic              hazard_s;
  logic              stall_s;
  logic              flush_d_s;
  logic              flush_e_s;

  // Writeback history shift register, advances every cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_we_q <= '0;
      for (int k = 0; k < HD; k++) hist_rd_q[k] <= 5'd0;
    end else begin
      hist_we_q[0] <= hz.regwrite_w;
      hist_rd_q[0] <= hz.rd_w;
      for (int k = 1; k < HD; k++) begin
        hist_we_q[k] <= hist_we_q[k-1];
        hist_rd_q[k] <= hist_rd_q[k-1];
      end
    end
  end

  // Forwarding select: walk lowest priority first so higher priority overwrites
  always_comb begin
    logic [4:0] src_v;
    logic [2:0] sel_v;
    fwd_sel_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_v = hz.src_e[5*i +: 5];
      sel_v = 3'd0;
      if (src_v != 5'd0) begin
        for (int k = HIST - 1; k >= 0; k--) begin
          if (hist_we_q[k] && (hist_rd_q[k] == src_v)) sel_v = 3'(3 + k);
          else                                         sel_v = sel_v;
        end
        if (hz.regwrite_w && (hz.rd_w == src_v)) sel_v = 3'd2;
        else                                     sel_v = sel_v;
        if (hz.regwrite_m && (hz.rd_m == src_v)) sel_v = 3'd1;
        else                                     sel_v = sel_v;
      end else begin
        sel_v = 3'd0;
      end
      fwd_sel_s[3*i +: 3] = sel_v;
    end
  end

  // Load-use detection against every decode-stage operand
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.src_d[5*i +: 5] == hz.rd_e) hazard_s = 1'b1;
      else                               hazard_s = hazard_s;
    end
    hazard_s = hazard_s & hz.memread_e & hz.regwrite_e & (hz.rd_e != 5'd0);
  end

  // Stall/flush decode; branch wins over any stall
  always_comb begin
    stall_s   = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    if (rst_i) begin
      stall_s   = 1'b0;
    end else if (hz.branch_taken_e) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if ((state_q == WAIT) || hazard_s) begin
      stall_s   = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_s   = 1'b0;
    end
  end

  // Load-use stall FSM; a hazard seen while waiting does not reload cnt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hz.branch_taken_e && hazard_s && (LOAD_LAT > 1)) begin
            state_q <= WAIT;
            cnt_q   <= 3'(LOAD_LAT - 1);
          end else begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end
        end
        WAIT: begin
          if (hz.branch_taken_e || (cnt_q <= 3'd1)) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end else begin
            state_q <= WAIT;
            cnt_q   <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  assign hz.fwd_sel = rst_i ? '0 : fwd_sel_s;
  assign hz.stall_f = stall_s;
  assign hz.stall_d = stall_s;
  assign hz.flush_d = flush_d_s;
  assign hz.flush_e = flush_e_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_s && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      else                                      stall_cnt_q <= stall_cnt_q;
      if (hz.branch_taken_e && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      else                                                flush_cnt_q <= flush_cnt_q;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (NSRC=2, HIST=2, LOAD_LAT=3); perf counters checked when
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;
  logic clk;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  hazard_ctrl_if #(.NSRC(2)) hz ();

  hazard_ctrl_unit #(.NSRC(2), .HIST(2), .LOAD_LAT(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    hz.src_d = 10'd0;  hz.src_e = 10'd0;
    hz.regwrite_e = 1'b0; hz.memread_e = 1'b0; hz.rd_e = 5'd0;
    hz.regwrite_m = 1'b0; hz.rd_m = 5'd0;
    hz.regwrite_w = 1'b0; hz.rd_w = 5'd0;
    hz.branch_taken_e = 1'b0;
  endtask

  task automatic load9();
    hz.memread_e = 1'b1; hz.regwrite_e = 1'b1; hz.rd_e = 5'd9;
    hz.src_d = {5'd9, 5'd0};
  endtask

  initial begin
    clr();
    rst = 1'b1;
    // outputs held at zero while in reset, even with forwarding/branch inputs active
    hz.regwrite_m = 1'b1; hz.rd_m = 5'd5; hz.src_e = {5'd0, 5'd5}; hz.branch_taken_e = 1'b1;
    settle();
    check("rst_fwd",     32'(hz.fwd_sel), 32'd0);
    check("rst_flush_d", 32'(hz.flush_d), 32'd0);
    check("rst_flush_e", 32'(hz.flush_e), 32'd0);
    check("rst_stall_d", 32'(hz.stall_d), 32'd0);
    tick(); tick();
    rst = 1'b0; clr(); tick();

    // M beats W, then W alone
    hz.regwrite_m = 1'b1; hz.rd_m = 5'd5; hz.regwrite_w = 1'b1; hz.rd_w = 5'd5;
    hz.src_e = {5'd0, 5'd5};
    settle(); check("fwd_m_over_w", 32'(hz.fwd_sel), 32'h01);
    hz.regwrite_m = 1'b0;
    settle(); check("fwd_w", 32'(hz.fwd_sel), 32'h02);

    // x0 never forwards; operand 1 packing
    hz.regwrite_m = 1'b1; hz.rd_m = 5'd0; hz.regwrite_w = 1'b1; hz.rd_w = 5'd0;
    hz.src_e = {5'd0, 5'd0};
    settle(); check("fwd_x0", 32'(hz.fwd_sel), 32'h00);
    hz.rd_m = 5'd3; hz.src_e = {5'd3, 5'd4};
    settle(); check("fwd_op1_m", 32'(hz.fwd_sel), 32'h08);
    clr(); tick();

    // history: x7 written at W ages through history 0, 1, then drops out
    hz.regwrite_w = 1'b1; hz.rd_w = 5'd7; hz.src_e = {5'd0, 5'd7};
    settle(); check("hist_w", 32'(hz.fwd_sel), 32'h02);
    tick(); hz.regwrite_w = 1'b0; hz.rd_w = 5'd0;
    settle(); check("hist_0", 32'(hz.fwd_sel), 32'h03);
    hz.regwrite_m = 1'b1; hz.rd_m = 5'd7;
    settle(); check("hist_m_prio", 32'(hz.fwd_sel), 32'h01);
    hz.regwrite_m = 1'b0;
    tick(); settle(); check("hist_1", 32'(hz.fwd_sel), 32'h04);
    tick(); settle(); check("hist_gone", 32'(hz.fwd_sel), 32'h00);
    clr(); tick();

    // non-hazards: load to x0, and a non-writing memread
    hz.memread_e = 1'b1; hz.regwrite_e = 1'b1; hz.rd_e = 5'd0; hz.src_d = 10'd0;
    settle(); check("nohaz_x0", 32'(hz.stall_d), 32'd0);
    hz.regwrite_e = 1'b0; hz.rd_e = 5'd9; hz.src_d = {5'd9, 5'd0};
    settle(); check("nohaz_nowr", 32'(hz.stall_d), 32'd0);
    clr(); tick();

    // load-use stall lasts LOAD_LAT=3 cycles
    load9(); settle();
    check("lu_c1", {28'd0, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e}, 32'b1101);
    tick(); clr(); settle();
    check("lu_c2", {30'd0, hz.stall_d, hz.flush_e}, 32'b11);
    tick(); settle();
    check("lu_c3", {30'd0, hz.stall_d, hz.flush_e}, 32'b11);
    tick(); settle();
    check("lu_done", {30'd0, hz.stall_d, hz.flush_e}, 32'b00);
    tick();

    // branch during second stall cycle cancels the stall
    load9(); tick(); clr(); hz.branch_taken_e = 1'b1; settle();
    check("br_wait", {28'd0, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e}, 32'b0011);
    tick(); clr(); settle();
    check("br_idle", {30'd0, hz.stall_d, hz.flush_e}, 32'b00);
    tick(); settle();
    check("br_idle2", 32'(hz.stall_d), 32'd0);

    // branch coincident with hazard starts no stall
    load9(); hz.branch_taken_e = 1'b1; settle();
    check("br_coinc", {28'd0, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e}, 32'b0011);
    tick(); clr(); settle();
    check("br_coinc_next", 32'(hz.stall_d), 32'd0);
    tick();

    // a repeated hazard while waiting does not restart the count
    load9(); tick(); settle();
    check("rehaz_c2", 32'(hz.stall_d), 32'd1);
    tick(); clr(); settle();
    check("rehaz_c3", 32'(hz.stall_d), 32'd1);
    tick(); settle();
    check("rehaz_done", 32'(hz.stall_d), 32'd0);
    tick();

    // reset mid-stall clears outputs at once, then FSM and history
    load9(); hz.regwrite_w = 1'b1; hz.rd_w = 5'd7; settle();
    check("rstw_pre", 32'(hz.stall_d), 32'd1);
    tick(); clr(); rst = 1'b1; hz.src_e = {5'd0, 5'd7}; settle();
    check("rstw_out", {29'd0, hz.stall_d, hz.flush_e, hz.flush_d}, 32'd0);
    check("rstw_fwd", 32'(hz.fwd_sel), 32'd0);
    tick(); rst = 1'b0; settle();
    check("rstw_hist", 32'(hz.fwd_sel), 32'd0);
    check("rstw_idle", 32'(hz.stall_d), 32'd0);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1; clr(); tick(); rst = 1'b0;
    load9(); tick(); clr(); tick(); tick(); settle();
    check("perf_stall", 32'(hz.stall_cnt), 32'd3);
    hz.branch_taken_e = 1'b1;
    for (int n = 0; n < 70000; n++) tick();
    settle();
    check("perf_flush_sat", 32'(hz.flush_cnt), 32'hFFFF);
    clr();
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter NSRC, default 2, number of register source operands checked per instruction (1..4).
REQ-002 Parameter HIST, default 1, number of post-writeback history stages used for forwarding (0..5).
REQ-003 Parameter LOAD_LAT, default 1, load-use stall length in cycles (1..7).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 src_d  in  NSRC*5  decode-stage source register indices; operand i occupies bits [5i+4:5i].
REQ-007 src_e  in  NSRC*5  execute-stage source register indices; same packing.
REQ-008 regwrite_e, memread_e  in  1 each  execute-stage instruction writes a register / is a load.
REQ-009 rd_e  in  5  execute-stage destination.
REQ-010 regwrite_m  in  1, rd_m  in  5  memory-stage write enable and destination.
REQ-011 regwrite_w  in  1, rd_w  in  5  writeback-stage write enable and destination.
REQ-012 branch_taken_e  in  1  control transfer resolved taken in execute.
REQ-013 fwd_sel  out  NSRC*3  per-operand forwarding select, operand i in bits [3i+2:3i].
REQ-014 stall_f, stall_d  out  1 each  hold fetch / decode registers.
REQ-015 flush_d, flush_e  out  1 each  clear decode / execute pipeline registers.

Function
REQ-016 fwd_sel encoding: 0 register file, 1 memory stage, 2 writeback stage, 3+k history stage k (k=0 youngest).
REQ-017 Operand i selects the highest-priority matching source: M, then W, then history 0..HIST-1; a source matches when its write enable is 1, its destination equals src_e operand i, and the destination is nonzero.
REQ-018 Index 0 never forwards; fwd_sel is 0 for any operand whose src_e index is 0.
REQ-019 History is a HIST-deep shift register of (regwrite_w, rd_w), advancing every cycle regardless of stall or flush; with HIST=0 codes 3..7 are never produced.
REQ-020 fwd_sel is combinational from inputs and history registers, with zero-cycle latency.
REQ-021 Load-use hazard: memread_e=1, regwrite_e=1, rd_e!=0, and rd_e equals any src_d operand.
REQ-022 FSM states IDLE and WAIT, with a 3-bit down-counter cnt.
REQ-023 IDLE: on a load-use hazard with branch_taken_e=0, assert stall_f, stall_d, flush_e in the same cycle; if LOAD_LAT>1, go to WAIT with cnt=LOAD_LAT-1, else remain in IDLE.
REQ-024 WAIT: assert stall_f, stall_d, flush_e; decrement cnt each cycle; go to IDLE in the cycle after the one in which cnt=1; total stall cycles equal LOAD_LAT.
REQ-025 branch_taken_e=1 asserts flush_d and flush_e in the same cycle and forces stall_f=stall_d=0 in that cycle.
REQ-026 A branch arriving in WAIT or coincident with a hazard moves the FSM to IDLE next cycle, and no stall is begun.
REQ-027 A new hazard detected in WAIT does not restart cnt.

Reset
REQ-028 While rst=1, all outputs are 0.
REQ-029 At the clock edge with rst=1, the FSM goes to IDLE, cnt to 0, and all history entries to (0,0); this holds mid-stall as well.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN: when defined, add outputs stall_cnt (out, 16) and flush_cnt (out, 16).
REQ-031 stall_cnt increments on each cycle with stall_d=1; flush_cnt increments on each cycle with branch_taken_e=1; both saturate at 0xFFFF and clear on rst.
REQ-032 When HAZARD_PERF_CNT_EN is undefined, these ports and registers are absent and all other behaviour is identical.

Verification
REQ-033 Apply regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, src_e op0=5 -> fwd_sel op0=1 (M beats W); then set regwrite_m=0 -> fwd_sel op0=2.
REQ-034 Apply rd_m=0, regwrite_m=1, src_e op1=0 -> fwd_sel op1=0; with HIST=2, write x7 at W, then src_e op0=7 one cycle later -> 3, two cycles later -> 4, three cycles later -> 0.
REQ-035 With LOAD_LAT=3, apply a load with rd_e=9 and src_d op1=9 -> stall_d=flush_e=1 for exactly 3 cycles, then 0.
REQ-036 With LOAD_LAT=3, pulse branch_taken_e in the second stall cycle -> flush_d=flush_e=1 and stall_d=0 that cycle, IDLE next cycle.
REQ-037 Assert rst during WAIT -> outputs 0 immediately, IDLE and history cleared after the edge, no stall after rst releases.
REQ-038 With HAZARD_PERF_CNT_EN defined, 70000 branch cycles -> flush_cnt=0xFFFF.
